// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Purpose  : Latches button presses into sticky pending requests and
//            sequences the car floor by floor with a travel timer and a
//            fixed door dwell. The next direction follows the rule "keep
//            going while requests remain ahead, reverse only when none do".
// Revision : 1.0  initial release
// ============================================================================
module elevator_scheduler #(
  parameter int FLOORS      = 10,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [FLOORS-1:0] buttons,
  input  logic [FLOORS-1:0] cancel,
  output logic [3:0]        Layer,
  output logic              Dir,
  output logic              Moving,
  output logic              DoorOpen,
  output logic [FLOORS-1:0] Pending
);

  // The timer only ever holds a load value of (cycles - 1).
  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_next;
  logic [3:0]        layer_next;
  logic              dir_next;
  logic [FLOORS-1:0] pending_next;
  logic [FLOORS-1:0] here_mask;
  logic [FLOORS-1:0] above_mask;
  logic [FLOORS-1:0] below_mask;
  logic              req_here;
  logic              req_above;
  logic              req_below;
  logic              ahead;
  logic              behind;
  logic              absorb;

  // Classify every floor as the current one, above it, or below it.
  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      here_mask[i]  = (Layer == 4'(i));
      above_mask[i] = (4'(i) > Layer);
      below_mask[i] = (4'(i) < Layer);
    end
  end

  assign req_here  = |(Pending & here_mask);
  assign req_above = |(Pending & above_mask);
  assign req_below = |(Pending & below_mask);
  assign ahead     = Dir ? req_above : req_below;
  assign behind    = Dir ? req_below : req_above;

  // Next-state, timer, position and request-latch logic.
  always_comb begin
    state_next = state;
    timer_next = timer;
    layer_next = Layer;
    dir_next   = Dir;
    absorb     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_here) begin
          state_next = S_DOOR;
          timer_next = DOOR_LOAD;
          absorb     = 1'b1;
        end else if (ahead) begin
          state_next = S_MOVE;
          timer_next = MOVE_LOAD;
        end else if (behind) begin
          state_next = S_MOVE;
          timer_next = MOVE_LOAD;
          dir_next   = ~Dir;
        end
      end
      S_MOVE: begin
        // A step already underway always completes, even if its target is cancelled.
        if (timer == '0) begin
          state_next = S_IDLE;
          layer_next = Dir ? (Layer + 4'd1) : (Layer - 4'd1);
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      S_DOOR: begin
        absorb = 1'b1;
        if (timer == '0) begin
          state_next = S_IDLE;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
    // Presses win over cancels; a press at the open floor is absorbed.
    pending_next = (Pending & ~cancel) | buttons;
    if (absorb) begin
      pending_next = pending_next & ~here_mask;
    end
  end

  // State, timer, position, direction and request registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      Layer   <= 4'd0;
      Dir     <= 1'b1;
      Pending <= '0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      Layer   <= layer_next;
      Dir     <= dir_next;
      Pending <= pending_next;
    end
  end

  assign Moving   = (state == S_MOVE);
  assign DoorOpen = (state == S_DOOR);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_elevator_scheduler
// Purpose  : Scenario and randomized checks of elevator_scheduler against a
//            cycle-level behavioural model of the request/dwell/travel rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_elevator_scheduler;

  localparam int FLOORS      = 10;
  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 3;
  localparam int VW          = FLOORS + 7;

  logic              CLK = 1'b0;
  logic              Reset_n = 1'b0;
  logic [FLOORS-1:0] buttons = '0;
  logic [FLOORS-1:0] cancel = '0;
  logic [3:0]        Layer;
  logic              Dir;
  logic              Moving;
  logic              DoorOpen;
  logic [FLOORS-1:0] Pending;
  logic [VW-1:0]     obs;

  int errors = 0;
  int checks = 0;

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  elevator_scheduler #(
    .FLOORS      (FLOORS),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .buttons  (buttons),
    .cancel   (cancel),
    .Layer    (Layer),
    .Dir      (Dir),
    .Moving   (Moving),
    .DoorOpen (DoorOpen),
    .Pending  (Pending)
  );

  assign obs = {Layer, Dir, Moving, DoorOpen, Pending};

  // Behavioural model: mode 0 idle, 1 travelling, 2 door open;
  // m_left counts the edges still to be spent in the current mode.
  int                m_floor;
  bit                m_dir;
  int                m_mode;
  int                m_left;
  bit [FLOORS-1:0]   m_pend;

  function automatic logic [FLOORS-1:0] onehot(input int f);
    logic [FLOORS-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {4'(m_floor), m_dir, (m_mode == 1), (m_mode == 2), m_pend};
  endfunction

  function automatic void model_reset();
    m_floor = 0;
    m_dir   = 1'b1;
    m_mode  = 0;
    m_left  = 0;
    m_pend  = '0;
  endfunction

  function automatic void model_step(input logic [FLOORS-1:0] b, input logic [FLOORS-1:0] c);
    bit [FLOORS-1:0] np;
    bit up, dn, at_door;
    int here;
    here    = m_floor;
    np      = (m_pend & ~c) | b;
    at_door = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (m_pend[f] && f > m_floor) up = 1'b1;
      if (m_pend[f] && f < m_floor) dn = 1'b1;
    end
    if (m_mode == 0) begin
      if (m_pend[m_floor]) begin
        m_mode = 2; m_left = DOOR_CYCLES; at_door = 1'b1;
      end else if (m_dir ? up : dn) begin
        m_mode = 1; m_left = MOVE_CYCLES;
      end else if (m_dir ? dn : up) begin
        m_dir = !m_dir; m_mode = 1; m_left = MOVE_CYCLES;
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
        m_mode  = 0;
      end
    end else begin
      at_door = 1'b1;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    if (at_door) np[here] = 1'b0;
    m_pend = np;
  endfunction

  // Drive inputs, take one rising edge in both DUT and model, settle.
  task automatic tick(input logic [FLOORS-1:0] b, input logic [FLOORS-1:0] c);
    buttons = b;
    cancel  = c;
    @(posedge CLK);
    model_step(b, c);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    buttons = '0;
    cancel  = '0;
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, {FLOORS{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, {4'd0, 1'b1, 1'b0, 1'b0, {FLOORS{1'b0}}});
    end
  endtask

  task automatic test_floor0();
    int first_door, door_cnt;
    bit moved;
    do_reset();
    first_door = -1; door_cnt = 0; moved = 1'b0;
    tick(onehot(0), '0);
    for (int k = 1; k <= 8; k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL floor0_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      if (DoorOpen) begin
        door_cnt++;
        if (first_door < 0) first_door = k;
      end
      if (Layer != 4'd0 || Moving) moved = 1'b1;
    end
    checks++;
    if (first_door !== 1) begin
      errors++; $display("FAIL floor0_door_start: got edge %0d want edge 1", first_door);
    end
    checks++;
    if (door_cnt !== DOOR_CYCLES) begin
      errors++; $display("FAIL floor0_door_len: got %0d want %0d", door_cnt, DOOR_CYCLES);
    end
    checks++;
    if (moved || Pending !== '0) begin
      errors++; $display("FAIL floor0_stay: moved=%0d pending=%h want moved=0 pending=0", moved, Pending);
    end
  endtask

  task automatic test_two_floors();
    int t1, t2, td, tc;
    do_reset();
    t1 = -1; t2 = -1; td = -1; tc = -1;
    tick(onehot(2), '0);
    checks++;
    if (Pending !== onehot(2)) begin
      errors++; $display("FAIL two_pending_latch: got %h want %h", Pending, onehot(2));
    end
    for (int k = 1; k <= 20; k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL two_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      if (t1 < 0 && Layer == 4'd1) t1 = k;
      if (t2 < 0 && Layer == 4'd2) t2 = k;
      if (td < 0 && DoorOpen) td = k;
      if (td > 0 && tc < 0 && !DoorOpen) tc = k;
    end
    checks++;
    if (t1 !== 5 || t2 !== 10 || td !== 11 || tc !== 14) begin
      errors++;
      $display("FAIL two_timing: got L1@%0d L2@%0d door@%0d close@%0d want 5 10 11 14", t1, t2, td, tc);
    end
    checks++;
    if (Pending !== '0 || Moving || DoorOpen || Layer !== 4'd2) begin
      errors++; $display("FAIL two_final: got %h want layer 2 idle no pending", obs);
    end
  endtask

  task automatic test_cancel();
    int stops[$];
    bit prev_door, reached;
    do_reset();
    prev_door = 1'b0; reached = 1'b0;
    tick(onehot(7) | onehot(8) | onehot(9), '0);
    for (int k = 0; k < 200 && !reached; k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL cancel_pre_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      if (DoorOpen && !prev_door) stops.push_back(int'(Layer));
      prev_door = DoorOpen;
      reached = (Layer == 4'd3) && Moving;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL cancel_reach: never between floors 3 and 4, layer=%0d", Layer);
    end
    tick('0, onehot(7));
    for (int k = 0; k < 200 && !(!Moving && !DoorOpen && Pending == '0); k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL cancel_post_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      if (DoorOpen && !prev_door) stops.push_back(int'(Layer));
      prev_door = DoorOpen;
    end
    checks++;
    if (stops.size() != 2 || stops[0] != 8 || stops[1] != 9) begin
      errors++; $display("FAIL cancel_stops: got %p want '{8, 9}", stops);
    end
    checks++;
    if (Pending !== '0 || Layer !== 4'd9) begin
      errors++; $display("FAIL cancel_final: got layer %0d pending %h want 9 and 0", Layer, Pending);
    end
  endtask

  task automatic test_reverse();
    int stops[$];
    int dirs[$];
    bit prev_door, reached;
    do_reset();
    prev_door = 1'b0; reached = 1'b0;
    tick(onehot(8), '0);
    for (int k = 0; k < 200 && !reached; k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL reverse_pre_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      reached = (Layer == 4'd5) && Moving;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL reverse_reach: never moving from floor 5, layer=%0d", Layer);
    end
    tick(onehot(0), '0);
    for (int k = 0; k < 300 && !(!Moving && !DoorOpen && Pending == '0); k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL reverse_post_cycle%0d: got %h want %h", k, obs, model_vec());
      end
      if (DoorOpen && !prev_door) begin
        stops.push_back(int'(Layer));
        dirs.push_back(int'(Dir));
      end
      prev_door = DoorOpen;
    end
    checks++;
    if (stops.size() != 2 || stops[0] != 8 || stops[1] != 0 || dirs[0] != 1 || dirs[1] != 0) begin
      errors++; $display("FAIL reverse_stops: got stops %p dirs %p want '{8, 0} '{1, 0}", stops, dirs);
    end
  endtask

  task automatic test_set_wins_and_absorb();
    int door_cnt;
    do_reset();
    door_cnt = 0;
    tick(onehot(4), onehot(4));
    checks++;
    if (Pending !== onehot(4)) begin
      errors++; $display("FAIL set_wins: got %h want %h", Pending, onehot(4));
    end
    for (int k = 0; k < 100 && !DoorOpen; k++) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL absorb_travel_cycle%0d: got %h want %h", k, obs, model_vec());
      end
    end
    for (int k = 0; k < 20 && DoorOpen; k++) begin
      door_cnt++;
      tick(onehot(4), '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL absorb_door_cycle%0d: got %h want %h", k, obs, model_vec());
      end
    end
    tick('0, '0);
    checks++;
    if (door_cnt !== DOOR_CYCLES || Pending !== '0 || DoorOpen || Layer !== 4'd4) begin
      errors++;
      $display("FAIL absorb_door: got door %0d pending %h open %0d layer %0d want %0d 0 0 4",
               door_cnt, Pending, DoorOpen, Layer, DOOR_CYCLES);
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    do_reset();
    reached = 1'b0;
    tick(onehot(9), '0);
    for (int k = 0; k < 200 && !reached; k++) begin
      tick('0, '0);
      reached = (Layer == 4'd6) && Moving;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL async_reach: never moving from floor 6, layer=%0d", Layer);
    end
    buttons = '0;
    cancel  = '0;
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, {FLOORS{1'b0}}}) begin
      errors++; $display("FAIL async_reset: got %h want %h", obs, {4'd0, 1'b1, 1'b0, 1'b0, {FLOORS{1'b0}}});
    end
    model_reset();
    #1;
    Reset_n = 1'b1;
    repeat (3) begin
      tick('0, '0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL async_after: got %h want %h", obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [FLOORS-1:0] b, c;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      b = ($urandom_range(0, 5) == 0) ? onehot(int'($urandom_range(0, FLOORS - 1))) : '0;
      if ($urandom_range(0, 40) == 0) b = b | FLOORS'($urandom);
      c = ($urandom_range(0, 9) == 0) ? onehot(int'($urandom_range(0, FLOORS - 1))) : '0;
      tick(b, c);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", k, obs, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_floor0();
    test_two_floors();
    test_cancel();
    test_reverse();
    test_set_wins_and_absorb();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
